icache_assoc: RTL and testbench

//  Parametrised set-associative instruction cache between IF and the memory allocator.

---
 rtl/icache_assoc_pkg.sv | 21 ++
 rtl/icache_way_store.sv | 55 +++++
 rtl/icache_assoc.sv | 261 ++++++++++++++++++++++++++
 tb/tb_icache_assoc.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_assoc_pkg.sv
// rtl/icache_assoc_pkg.sv - shared types and helpers for the set-associative icache
package icache_assoc_pkg;

  // Line fill sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fill_state_e;

  // Instruction words are 4 bytes: two byte-offset bits below the word index
  localparam int unsigned BYTE_OFS    = 2;
  // Each allocator beat moves one 4-byte word, reported as bytes-1
  localparam logic [1:0]  BEAT_OFFSET = 2'd3;

  // Index width that stays legal (>=1) even when the count degenerates to 1
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_way_store.sv
// rtl/icache_way_store.sv - one cache way: valid bits, tags and line data per set
module icache_way_store
  import icache_assoc_pkg::*;
#(
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TAG_W      = 22,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned WRD_W      = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_flush,
  input  logic [IDX_W-1:0]                 i_rd_idx,
  input  logic [WRD_W-1:0]                 i_rd_word,
  output logic                             o_rd_valid,
  output logic [TAG_W-1:0]                 o_rd_tag,
  output logic [DATA_WIDTH-1:0]            o_rd_data,
  input  logic                             i_wr_en,
  input  logic [IDX_W-1:0]                 i_wr_idx,
  input  logic [TAG_W-1:0]                 i_wr_tag,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] i_wr_line
);

  logic [SETS-1:0]       r_valid;
  logic [TAG_W-1:0]      r_tag  [SETS];
  logic [DATA_WIDTH-1:0] r_data [SETS][LINE_WORDS];

  // Valid bits: cleared by reset or flush, set when a completed line is installed
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and line payload: plain storage, meaningless until the valid bit is set
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx] <= i_wr_tag;
      for (int i = 0; i < LINE_WORDS; i++) begin
        r_data[i_wr_idx][i] <= i_wr_line[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx][i_rd_word];

endmodule

// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - set-associative instruction cache with multi-beat line fill
module icache_assoc
  import icache_assoc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  if_to_icache_en_in,
  input  logic [ADDR_WIDTH-1:0] if_a_in,
  output logic                  icache_to_if_en_out,
  output logic [DATA_WIDTH-1:0] if_d_out,
  output logic                  if_to_alloc_en_out,
  output logic [ADDR_WIDTH-1:0] if_a_out,
  output logic [1:0]            if_offset_out,
  input  logic                  alloc_to_if_gr_in,
  input  logic                  alloc_to_if_en_in,
  input  logic [DATA_WIDTH-1:0] if_d_in,
  input  logic                  clear_branch_in,
  input  logic                  flush_in
);

  localparam int unsigned OFS   = BYTE_OFS;
  localparam int unsigned WB    = $clog2(LINE_WORDS);
  localparam int unsigned IB    = $clog2(SETS);
  localparam int unsigned TAG   = ADDR_WIDTH - IB - WB - OFS;
  localparam int unsigned IDX_W = idx_bits(SETS);
  localparam int unsigned WRD_W = idx_bits(LINE_WORDS);
  localparam int unsigned WAY_W = idx_bits(WAYS);

  // Address field extraction: tag | set | word | byte offset
  function automatic logic [IDX_W-1:0] f_set(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a >> (OFS + WB)) & ADDR_WIDTH'(SETS - 1));
  endfunction

  function automatic logic [WRD_W-1:0] f_word(input logic [ADDR_WIDTH-1:0] a);
    return WRD_W'((a >> OFS) & ADDR_WIDTH'(LINE_WORDS - 1));
  endfunction

  function automatic logic [TAG-1:0] f_tag(input logic [ADDR_WIDTH-1:0] a);
    return TAG'(a >> (OFS + WB + IB));
  endfunction

  fill_state_e           r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_req_addr, w_req_addr_nxt;
  logic [WRD_W-1:0]      r_beat, w_beat_nxt;
  logic                  r_alloc_en, w_alloc_en_nxt;
  logic [ADDR_WIDTH-1:0] r_a_out, w_a_out_nxt;
  logic                  r_en_out, w_en_out_nxt;
  logic [DATA_WIDTH-1:0] r_d_out, w_d_out_nxt;
  logic [DATA_WIDTH-1:0] r_fill_buf [LINE_WORDS];
  logic [WAY_W-1:0]      r_rr [SETS];

  logic [IDX_W-1:0]      w_rd_idx;
  logic [IDX_W-1:0]      w_fill_set;
  logic [WAYS-1:0]       w_way_valid;
  logic [WAYS-1:0]       w_way_hit;
  logic [WAYS-1:0]       w_way_we;
  logic [TAG-1:0]        w_way_tag  [WAYS];
  logic [DATA_WIDTH-1:0] w_way_data [WAYS];
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_hit_data;
  logic [WAY_W-1:0]      w_victim;
  logic                  w_found_free;
  logic [LINE_WORDS*DATA_WIDTH-1:0] w_line;
  logic [DATA_WIDTH-1:0] w_fill_word;
  logic                  w_abort;
  logic                  w_take_word;
  logic                  w_last_beat;
  logic                  w_install;
  logic                  w_flush_en;

  // In IDLE the arrays are probed with the incoming fetch; during a fill they
  // show the set being filled so the victim choice sees its valid bits.
  assign w_rd_idx   = (r_state == ST_IDLE) ? f_set(if_a_in) : f_set(r_req_addr);
  assign w_fill_set = f_set(r_req_addr);
  assign w_flush_en = rdy_in & flush_in;

  generate
    for (genvar g = 0; g < WAYS; g++) begin : g_way
      icache_way_store #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W),
        .WRD_W      (WRD_W)
      ) u_way (
        .i_clk      (clk_in),
        .i_rst      (rst_in),
        .i_flush    (w_flush_en),
        .i_rd_idx   (w_rd_idx),
        .i_rd_word  (f_word(if_a_in)),
        .o_rd_valid (w_way_valid[g]),
        .o_rd_tag   (w_way_tag[g]),
        .o_rd_data  (w_way_data[g]),
        .i_wr_en    (w_way_we[g]),
        .i_wr_idx   (w_fill_set),
        .i_wr_tag   (f_tag(r_req_addr)),
        .i_wr_line  (w_line)
      );
    end
  endgenerate

  // Tag compare across all ways and one-hot data mux for the hit word
  always_comb begin
    w_way_hit  = '0;
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_way_hit[w] = w_way_valid[w] && (w_way_tag[w] == f_tag(if_a_in));
      if (w_way_hit[w]) begin
        w_hit      = 1'b1;
        w_hit_data = w_hit_data | w_way_data[w];
      end
    end
  end

  // Victim: first free way in the set, otherwise the set's round-robin pointer
  always_comb begin
    w_victim     = (WAYS == 1) ? '0 : r_rr[w_fill_set];
    w_found_free = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_found_free && !w_way_valid[w]) begin
        w_victim     = WAY_W'(w);
        w_found_free = 1'b1;
      end
    end
  end

  // Completed line: buffered beats plus the word arriving on this cycle as the last
  always_comb begin
    w_line = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      w_line[i*DATA_WIDTH +: DATA_WIDTH] = (i == LINE_WORDS - 1) ? if_d_in : r_fill_buf[i];
    end
    w_fill_word = (f_word(r_req_addr) == WRD_W'(LINE_WORDS - 1)) ? if_d_in
                                                                 : r_fill_buf[f_word(r_req_addr)];
  end

  assign w_abort     = clear_branch_in | flush_in;
  assign w_take_word = !w_abort && alloc_to_if_en_in &&
                       ((r_state == ST_WAIT) || (r_state == ST_REQ && alloc_to_if_gr_in));
  assign w_last_beat = (r_beat == WRD_W'(LINE_WORDS - 1));
  assign w_install   = rdy_in && w_take_word && w_last_beat;

  // Install the finished line into the victim way only
  always_comb begin
    w_way_we = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_way_we[w] = w_install && (w_victim == WAY_W'(w));
    end
  end

  // Fill FSM next-state and registered-output values
  always_comb begin
    w_state_nxt    = r_state;
    w_req_addr_nxt = r_req_addr;
    w_beat_nxt     = r_beat;
    w_alloc_en_nxt = r_alloc_en;
    w_a_out_nxt    = r_a_out;
    w_en_out_nxt   = 1'b0;
    w_d_out_nxt    = r_d_out;
    if (w_abort) begin
      w_state_nxt    = ST_IDLE;
      w_alloc_en_nxt = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (if_to_icache_en_in) begin
            if (w_hit) begin
              w_en_out_nxt = 1'b1;
              w_d_out_nxt  = w_hit_data;
            end else begin
              w_req_addr_nxt = if_a_in;
              w_beat_nxt     = '0;
              w_a_out_nxt    = if_a_in & ~ADDR_WIDTH'(LINE_WORDS * 4 - 1);
              w_alloc_en_nxt = 1'b1;
              w_state_nxt    = ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (alloc_to_if_gr_in) begin
            w_alloc_en_nxt = 1'b0;
            w_state_nxt    = ST_WAIT;
          end
        end
        ST_WAIT: begin
        end
        default: begin
          w_state_nxt    = ST_IDLE;
          w_alloc_en_nxt = 1'b0;
        end
      endcase
      if (w_take_word) begin
        if (!w_last_beat) begin
          w_beat_nxt     = r_beat + WRD_W'(1);
          w_a_out_nxt    = r_a_out + ADDR_WIDTH'(4);
          w_alloc_en_nxt = 1'b1;
          w_state_nxt    = ST_REQ;
        end else begin
          w_en_out_nxt = 1'b1;
          w_d_out_nxt  = w_fill_word;
          w_state_nxt  = ST_IDLE;
        end
      end
    end
  end

  // FSM state and output registers; everything holds while rdy_in is low
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= ST_IDLE;
      r_req_addr <= '0;
      r_beat     <= '0;
      r_alloc_en <= 1'b0;
      r_a_out    <= '0;
      r_en_out   <= 1'b0;
      r_d_out    <= '0;
    end else if (rdy_in) begin
      r_state    <= w_state_nxt;
      r_req_addr <= w_req_addr_nxt;
      r_beat     <= w_beat_nxt;
      r_alloc_en <= w_alloc_en_nxt;
      r_a_out    <= w_a_out_nxt;
      r_en_out   <= w_en_out_nxt;
      r_d_out    <= w_d_out_nxt;
    end
  end

  // Capture each returned beat into the fill buffer
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && w_take_word) begin
      r_fill_buf[r_beat] <= if_d_in;
    end
  end

  // Per-set round-robin pointer advances on every install into that set
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int s = 0; s < SETS; s++) begin
        r_rr[s] <= '0;
      end
    end else if (w_install) begin
      r_rr[w_fill_set] <= r_rr[w_fill_set] + WAY_W'(1);
    end
  end

  assign icache_to_if_en_out = r_en_out;
  assign if_d_out            = r_d_out;
  assign if_to_alloc_en_out  = r_alloc_en;
  assign if_a_out            = r_a_out;
  assign if_offset_out       = BEAT_OFFSET;

endmodule

// File: tb/tb_icache_assoc.sv
// tb/tb_icache_assoc.sv - directed self-checking bench for icache_assoc
module tb_icache_assoc;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_to_icache_en_in;
  logic [31:0] if_a_in;
  logic        icache_to_if_en_out;
  logic [31:0] if_d_out;
  logic        if_to_alloc_en_out;
  logic [31:0] if_a_out;
  logic [1:0]  if_offset_out;
  logic        alloc_to_if_gr_in;
  logic        alloc_to_if_en_in;
  logic [31:0] if_d_in;
  logic        clear_branch_in;
  logic        flush_in;

  int total = 0;
  int bad   = 0;

  icache_assoc #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .WAYS       (2),
    .SETS       (64),
    .LINE_WORDS (4)
  ) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .rdy_in              (rdy_in),
    .if_to_icache_en_in  (if_to_icache_en_in),
    .if_a_in             (if_a_in),
    .icache_to_if_en_out (icache_to_if_en_out),
    .if_d_out            (if_d_out),
    .if_to_alloc_en_out  (if_to_alloc_en_out),
    .if_a_out            (if_a_out),
    .if_offset_out       (if_offset_out),
    .alloc_to_if_gr_in   (alloc_to_if_gr_in),
    .alloc_to_if_en_in   (alloc_to_if_en_in),
    .if_d_in             (if_d_in),
    .clear_branch_in     (clear_branch_in),
    .flush_in            (flush_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Allocator model: grant a held request, return its word a cycle later
  // (or in the same cycle when mode_same is set). Handshakes count only if
  // rdy_in was high and no abort was present during that cycle.
  bit          mode_same = 0;
  bit          stall     = 0;
  bit          pend      = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] p_addr    = '0;
  bit          p_gr = 0, p_en = 0, p_rdy = 0, p_abort = 0;
  logic [31:0] glog[$];

  initial begin
    alloc_to_if_gr_in = 1'b0;
    alloc_to_if_en_in = 1'b0;
    if_d_in           = '0;
    forever begin
      @(posedge clk_in);
      #2;
      if (rst_in) begin
        pend = 0;
      end else if (p_rdy) begin
        if (p_abort) begin
          pend = 0;
        end else begin
          if (p_en) pend = 0;
          if (p_gr) begin
            glog.push_back(p_addr);
            if (!p_en) begin
              pend      = 1;
              pend_addr = p_addr;
            end
          end
        end
      end
      alloc_to_if_gr_in = 1'b0;
      alloc_to_if_en_in = 1'b0;
      if (!rst_in && pend) begin
        alloc_to_if_en_in = 1'b1;
        if_d_in           = mem_word(pend_addr);
      end else if (!rst_in && if_to_alloc_en_out && !stall) begin
        alloc_to_if_gr_in = 1'b1;
        p_addr            = if_a_out;
        if (mode_same) begin
          alloc_to_if_en_in = 1'b1;
          if_d_in           = mem_word(if_a_out);
        end
      end
      p_gr    = alloc_to_if_gr_in;
      p_en    = alloc_to_if_en_in;
      p_rdy   = rdy_in;
      p_abort = clear_branch_in | flush_in;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic start_req(input logic [31:0] a);
    if_to_icache_en_in = 1'b1;
    if_a_in            = a;
    tick();
    if_to_icache_en_in = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] d, output int lat);
    lat = 1;
    while (!icache_to_if_en_out && lat < 60) begin
      tick();
      lat++;
    end
    d = if_d_out;
  endtask

  task automatic fetch(input string tag, input logic [31:0] a,
                       input logic [31:0] exp_d, input int exp_lat);
    logic [31:0] d;
    int          lat;
    start_req(a);
    wait_resp(d, lat);
    check_eq({tag, "_data"}, d, exp_d);
    check_eq({tag, "_lat"}, lat, exp_lat);
    tick();
  endtask

  initial begin
    int cnt;
    logic [31:0] d;
    int lat;
    rst_in             = 1'b1;
    rdy_in             = 1'b1;
    if_to_icache_en_in = 1'b0;
    if_a_in            = '0;
    clear_branch_in    = 1'b0;
    flush_in           = 1'b0;
    repeat (3) tick();
    check_eq("rst_en_out", icache_to_if_en_out, 0);
    check_eq("rst_alloc_en", if_to_alloc_en_out, 0);
    check_eq("rst_a_out", if_a_out, 0);
    check_eq("rst_d_out", if_d_out, 0);
    check_eq("offset", if_offset_out, 3);
    rst_in = 1'b0;
    tick();

    // cold miss, beat addresses, then hits in the same line
    glog.delete();
    fetch("cold100", 32'h100, 32'hC0DE0100, 9);
    check_eq("cold_beats", glog.size(), 4);
    check_eq("beat0", glog[0], 32'h100);
    check_eq("beat1", glog[1], 32'h104);
    check_eq("beat2", glog[2], 32'h108);
    check_eq("beat3", glog[3], 32'h10C);
    check_eq("en_pulse", icache_to_if_en_out, 0);
    fetch("hit108", 32'h108, 32'hC0DE0108, 1);
    fetch("hit10c", 32'h10C, 32'hC0DE010C, 1);

    // requested word is the last beat: forwarded straight from the allocator
    fetch("fwd20c", 32'h20C, 32'hC0DE020C, 9);

    // replacement in set 0x10: A=0x100 way0, B=0x500 way1, C=0x900 evicts A
    fetch("missB", 32'h500, 32'hC0DE0500, 9);
    fetch("missC", 32'h900, 32'hC0DE0900, 9);
    fetch("hitB", 32'h504, 32'hC0DE0504, 1);
    fetch("missA", 32'h104, 32'hC0DE0104, 9);
    fetch("hitC", 32'h904, 32'hC0DE0904, 1);

    // clear_branch during beat 2 discards the partial line
    start_req(32'h300);
    cnt = 0;
    while (!(if_to_alloc_en_out && if_a_out == 32'h308) && cnt < 60) begin
      tick();
      cnt++;
    end
    check_eq("clr_at_beat2", if_a_out, 32'h308);
    clear_branch_in = 1'b1;
    tick();
    clear_branch_in = 1'b0;
    check_eq("clr_alloc_drop", if_to_alloc_en_out, 0);
    check_eq("clr_no_resp", icache_to_if_en_out, 0);
    repeat (2) tick();
    glog.delete();
    fetch("clr_refetch", 32'h300, 32'hC0DE0300, 9);
    check_eq("clr_refetch_beats", glog.size(), 4);

    // warm hits, flush, then everything misses
    fetch("warm304", 32'h304, 32'hC0DE0304, 1);
    fetch("warm104", 32'h104, 32'hC0DE0104, 1);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    tick();
    fetch("fl304", 32'h304, 32'hC0DE0304, 9);
    fetch("fl904", 32'h904, 32'hC0DE0904, 9);
    fetch("fl104", 32'h104, 32'hC0DE0104, 9);

    // flush coincident with the final beat: nothing installed
    start_req(32'h600);
    cnt = 0;
    while (!(if_to_alloc_en_out && if_a_out == 32'h60C) && cnt < 60) begin
      tick();
      cnt++;
    end
    check_eq("fl_mid_last", if_a_out, 32'h60C);
    tick();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    check_eq("fl_mid_no_resp", icache_to_if_en_out, 0);
    tick();
    fetch("fl_mid_refetch", 32'h600, 32'hC0DE0600, 9);

    // rdy_in low for 5 cycles while waiting for a grant
    stall = 1;
    start_req(32'h700);
    check_eq("rdy_pre_en", if_to_alloc_en_out, 1);
    check_eq("rdy_pre_a", if_a_out, 32'h700);
    rdy_in = 1'b0;
    stall  = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("rdy_hold_en", if_to_alloc_en_out, 1);
      check_eq("rdy_hold_a", if_a_out, 32'h700);
    end
    rdy_in = 1'b1;
    wait_resp(d, lat);
    check_eq("rdy_resume_data", d, 32'hC0DE0700);
    check_eq("rdy_resume_lat", lat, 9);
    tick();

    // grant and data together on every beat
    mode_same = 1;
    glog.delete();
    fetch("same_a00", 32'hA00, 32'hC0DE0A00, 5);
    check_eq("same_beats", glog.size(), 4);
    check_eq("same_beat3", glog[3], 32'hA0C);
    fetch("same_hit", 32'hA08, 32'hC0DE0A08, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
